// File: rtl/sram_bus_arbiter.sv
// N-master arbiter merging upstream SRAM-style read/write buses onto one downstream bus.
// Reads may be pipelined up to RD_DEPTH deep; an in-order owner FIFO steers responses back.
module sram_bus_arbiter #(
    parameter int N_MST    = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 256,
    parameter int TYPE_W   = 6,
    parameter int STRB_W   = 16,
    parameter int RD_DEPTH = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_MST-1:0]           r_req,
    input  logic [N_MST*ADDR_W-1:0]    r_addr,
    input  logic [N_MST*TYPE_W-1:0]    r_type,
    output logic [N_MST-1:0]           r_rdy,
    output logic [DATA_W-1:0]          re_data,
    output logic [N_MST-1:0]           re_valid,
    input  logic [N_MST-1:0]           w_req,
    input  logic [N_MST*ADDR_W-1:0]    w_addr,
    input  logic [N_MST*TYPE_W-1:0]    w_type,
    input  logic [N_MST*STRB_W-1:0]    w_strb,
    input  logic [N_MST*DATA_W-1:0]    w_data,
    output logic [N_MST-1:0]           w_rdy,
    output logic                       m_r_req,
    output logic [ADDR_W-1:0]          m_r_addr,
    output logic [TYPE_W-1:0]          m_r_type,
    input  logic                       m_r_rdy,
    input  logic [DATA_W-1:0]          m_re_data,
    input  logic                       m_re_valid,
    output logic                       m_w_req,
    output logic [ADDR_W-1:0]          m_w_addr,
    output logic [TYPE_W-1:0]          m_w_type,
    output logic [STRB_W-1:0]          m_w_strb,
    output logic [DATA_W-1:0]          m_w_data,
    input  logic                       m_w_rdy,
    output logic [$clog2(RD_DEPTH):0]  rd_cnt,
    output logic                       rsp_err
);
    localparam int OWN_W = $clog2(N_MST);
    localparam int CNT_W = $clog2(RD_DEPTH) + 1;
    localparam int PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

    // Round-robin: first requester at or above ptr, else the lowest requester (wrap).
    function automatic logic [OWN_W-1:0] pick(input logic [N_MST-1:0] req,
                                              input logic [OWN_W-1:0] ptr);
        logic [OWN_W-1:0] hi, lo;
        logic             hi_found, lo_found;
        hi = '0; lo = '0; hi_found = 1'b0; lo_found = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            if (req[i]) begin
                if (!lo_found) begin
                    lo       = OWN_W'(i);
                    lo_found = 1'b1;
                end
                if (!hi_found && OWN_W'(i) >= ptr) begin
                    hi       = OWN_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        return (ARB_MODE == 0 && hi_found) ? hi : lo;
    endfunction

    function automatic logic [OWN_W-1:0] next_own(input logic [OWN_W-1:0] g);
        return (g == OWN_W'(N_MST - 1)) ? '0 : g + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [OWN_W-1:0] rd_rr_q, rd_rr_d, wr_rr_q, wr_rr_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             rsp_err_q, rsp_err_d;
    logic [OWN_W-1:0] fifo_q [2**PTR_W];

    logic [OWN_W-1:0] rd_gnt, wr_gnt;
    logic             rd_full, rd_acc, rd_pop, wr_acc;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        rd_gnt   = pick(r_req, rd_rr_q);
        wr_gnt   = pick(w_req, wr_rr_q);
        rd_full  = (rd_cnt_q == CNT_W'(RD_DEPTH));
        m_r_req  = (|r_req) & ~rd_full;
        m_w_req  = |w_req;
        rd_acc   = m_r_req & m_r_rdy;
        wr_acc   = m_w_req & m_w_rdy;
        rd_pop   = m_re_valid & (rd_cnt_q != '0);

        r_rdy    = '0;
        w_rdy    = '0;
        re_valid = '0;
        m_r_addr = '0;
        m_r_type = '0;
        m_w_addr = '0;
        m_w_type = '0;
        m_w_strb = '0;
        m_w_data = '0;
        re_data  = m_re_valid ? m_re_data : '0;

        for (int i = 0; i < N_MST; i++) begin
            if (r_req[i] && rd_gnt == OWN_W'(i)) begin
                r_rdy[i] = m_r_rdy & ~rd_full;
                m_r_addr = r_addr[i*ADDR_W +: ADDR_W];
                m_r_type = r_type[i*TYPE_W +: TYPE_W];
            end
            if (w_req[i] && wr_gnt == OWN_W'(i)) begin
                w_rdy[i] = m_w_rdy;
                m_w_addr = w_addr[i*ADDR_W +: ADDR_W];
                m_w_type = w_type[i*TYPE_W +: TYPE_W];
                m_w_strb = w_strb[i*STRB_W +: STRB_W];
                m_w_data = w_data[i*DATA_W +: DATA_W];
            end
            re_valid[i] = rd_pop && (fifo_q[head_q] == OWN_W'(i));
        end

        rd_rr_d   = (ARB_MODE == 0 && rd_acc) ? next_own(rd_gnt) : rd_rr_q;
        wr_rr_d   = (ARB_MODE == 0 && wr_acc) ? next_own(wr_gnt) : wr_rr_q;
        tail_d    = rd_acc ? next_ptr(tail_q) : tail_q;
        head_d    = rd_pop ? next_ptr(head_q) : head_q;
        rsp_err_d = rsp_err_q | (m_re_valid & (rd_cnt_q == '0));
        case ({rd_acc, rd_pop})
            2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
            2'b01:   rd_cnt_d = rd_cnt_q - 1'b1;
            default: rd_cnt_d = rd_cnt_q;
        endcase
    end

    // rst_n is active-high here: it is the core-wide reset net, asserted at 1.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_rr_q   <= '0;
            wr_rr_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            rd_cnt_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            rd_rr_q   <= rd_rr_d;
            wr_rr_q   <= wr_rr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rd_cnt_q  <= rd_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // NOTE: the owner storage is not reset; head/tail/count define which entries are valid.
    always_ff @(posedge clk) begin
        if (rd_acc) fifo_q[tail_q] <= rd_gnt;
    end

    assign rd_cnt  = rd_cnt_q;
    assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: round-robin instance plus a fixed-priority twin.
module tb_sram_bus_arbiter;
    localparam int N = 3, AW = 32, DW = 256, TW = 6, SW = 16, DEP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      r_req, w_req;
    logic [N*AW-1:0]   r_addr, w_addr;
    logic [N*TW-1:0]   r_type, w_type;
    logic [N*SW-1:0]   w_strb;
    logic [N*DW-1:0]   w_data;
    logic              m_r_rdy, m_re_valid, m_w_rdy;
    logic [DW-1:0]     m_re_data;

    logic [N-1:0]      r_rdy, re_valid, w_rdy;
    logic [DW-1:0]     re_data, m_w_data;
    logic              m_r_req, m_w_req, rsp_err;
    logic [AW-1:0]     m_r_addr, m_w_addr;
    logic [TW-1:0]     m_r_type, m_w_type;
    logic [SW-1:0]     m_w_strb;
    logic [2:0]        rd_cnt;

    logic [N-1:0]      fp_r_rdy, fp_re_valid, fp_w_rdy;
    logic [DW-1:0]     fp_re_data, fp_m_w_data;
    logic              fp_m_r_req, fp_m_w_req, fp_rsp_err;
    logic [AW-1:0]     fp_m_r_addr, fp_m_w_addr;
    logic [TW-1:0]     fp_m_r_type, fp_m_w_type;
    logic [SW-1:0]     fp_m_w_strb;
    logic [2:0]        fp_rd_cnt;

    sram_bus_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW), .STRB_W(SW),
                       .RD_DEPTH(DEP), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .r_req(r_req), .r_addr(r_addr), .r_type(r_type), .r_rdy(r_rdy),
        .re_data(re_data), .re_valid(re_valid),
        .w_req(w_req), .w_addr(w_addr), .w_type(w_type), .w_strb(w_strb), .w_data(w_data),
        .w_rdy(w_rdy),
        .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type), .m_r_rdy(m_r_rdy),
        .m_re_data(m_re_data), .m_re_valid(m_re_valid),
        .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_type(m_w_type), .m_w_strb(m_w_strb),
        .m_w_data(m_w_data), .m_w_rdy(m_w_rdy),
        .rd_cnt(rd_cnt), .rsp_err(rsp_err)
    );

    sram_bus_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW), .STRB_W(SW),
                       .RD_DEPTH(DEP), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .r_req(r_req), .r_addr(r_addr), .r_type(r_type), .r_rdy(fp_r_rdy),
        .re_data(fp_re_data), .re_valid(fp_re_valid),
        .w_req(w_req), .w_addr(w_addr), .w_type(w_type), .w_strb(w_strb), .w_data(w_data),
        .w_rdy(fp_w_rdy),
        .m_r_req(fp_m_r_req), .m_r_addr(fp_m_r_addr), .m_r_type(fp_m_r_type), .m_r_rdy(m_r_rdy),
        .m_re_data(m_re_data), .m_re_valid(m_re_valid),
        .m_w_req(fp_m_w_req), .m_w_addr(fp_m_w_addr), .m_w_type(fp_m_w_type),
        .m_w_strb(fp_m_w_strb), .m_w_data(fp_m_w_data), .m_w_rdy(m_w_rdy),
        .rd_cnt(fp_rd_cnt), .rsp_err(fp_rsp_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] DATA_A = {8{32'hA5A5_A5A5}};
    localparam logic [DW-1:0] DATA_B = {8{32'h1234_5678}};
    localparam logic [DW-1:0] DATA_C = {8{32'hC0DE_0000}};
    localparam logic [DW-1:0] DATA_D = {8{32'hD00D_FFFF}};

    int rr_g [4] = '{0, 1, 2, 0};
    int drain_g [4] = '{1, 2, 0, 1};

    initial begin
        rst_n = 1'b1;
        r_req = '0; r_addr = '0; r_type = '0;
        w_req = '0; w_addr = '0; w_type = '0; w_strb = '0; w_data = '0;
        m_r_rdy = 1'b0; m_re_valid = 1'b0; m_w_rdy = 1'b0; m_re_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst r_rdy", DW'(r_rdy), '0);
        check("rst re_valid", DW'(re_valid), '0);
        check("rst m_r_req", DW'(m_r_req), '0);
        check("rst m_w_req", DW'(m_w_req), '0);
        check("rst w_rdy", DW'(w_rdy), '0);
        check("rst rd_cnt", DW'(rd_cnt), '0);
        check("rst rsp_err", DW'(rsp_err), '0);
        check("rst re_data", re_data, '0);
        check("rst m_r_addr", DW'(m_r_addr), '0);
        check("rst m_w_data", m_w_data, '0);

        // single read from master 1
        r_req = 3'b010; r_addr[AW +: AW] = 32'h8000_0040; r_type[TW +: TW] = 6'h15;
        m_r_rdy = 1'b1;
        #1;
        check("single r_rdy", DW'(r_rdy), DW'(3'b010));
        check("single m_r_req", DW'(m_r_req), DW'(1'b1));
        check("single m_r_addr", DW'(m_r_addr), DW'(32'h8000_0040));
        check("single m_r_type", DW'(m_r_type), DW'(6'h15));
        cyc(); r_req = '0; #1;
        check("single rd_cnt=1", DW'(rd_cnt), DW'(1));
        check("single m_r_req idle", DW'(m_r_req), '0);
        cyc(); cyc();
        m_re_valid = 1'b1; m_re_data = DATA_A; #1;
        check("single re_valid", DW'(re_valid), DW'(3'b010));
        check("single re_data", re_data, DATA_A);
        cyc(); m_re_valid = 1'b0; m_re_data = '0; #1;
        check("single rd_cnt=0", DW'(rd_cnt), '0);
        check("single re_valid idle", DW'(re_valid), '0);

        // reset pulse between clock edges returns both pointers to 0
        rst_n = 1'b1; #1; rst_n = 1'b0; #1;

        // round-robin 0,1,2,0 then the depth limit
        r_req = 3'b111;
        r_addr = {32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr grant %0d", k), DW'(r_rdy), DW'(3'b001 << rr_g[k]));
            check($sformatf("rr addr %0d", k), DW'(m_r_addr), DW'(32'h100 * rr_g[k]));
            check($sformatf("fp grant %0d", k), DW'(fp_r_rdy), DW'(3'b001));
            cyc();
        end
        check("full m_r_req", DW'(m_r_req), '0);
        check("full r_rdy", DW'(r_rdy), '0);
        check("full rd_cnt", DW'(rd_cnt), DW'(4));
        cyc();
        check("full held", DW'(m_r_req), '0);
        m_re_valid = 1'b1; m_re_data = DATA_B; #1;
        check("full pop re_valid", DW'(re_valid), DW'(3'b001));
        check("full pop no accept", DW'(m_r_req), '0);
        cyc(); m_re_valid = 1'b0; #1;
        check("resume rd_cnt", DW'(rd_cnt), DW'(3));
        check("resume m_r_req", DW'(m_r_req), DW'(1'b1));
        check("resume r_rdy", DW'(r_rdy), DW'(3'b010));
        cyc(); r_req = '0; #1;
        check("refill rd_cnt", DW'(rd_cnt), DW'(4));
        for (int k = 0; k < 4; k++) begin
            m_re_valid = 1'b1; #1;
            check($sformatf("drain owner %0d", k), DW'(re_valid), DW'(3'b001 << drain_g[k]));
            cyc();
        end
        m_re_valid = 1'b0; #1;
        check("drain rd_cnt", DW'(rd_cnt), '0);

        // accept order 2,0,2 with one simultaneous accept+response at rd_cnt=2
        r_req = 3'b100; #1; check("ooo acc 2", DW'(r_rdy), DW'(3'b100));
        cyc(); r_req = 3'b001; #1; check("ooo acc 0", DW'(r_rdy), DW'(3'b001));
        cyc(); r_req = 3'b100; #1; check("ooo acc 2b", DW'(r_rdy), DW'(3'b100));
        cyc(); r_req = '0; #1; check("ooo rd_cnt", DW'(rd_cnt), DW'(3));
        m_re_valid = 1'b1; #1; check("ooo rsp 100", DW'(re_valid), DW'(3'b100));
        cyc(); r_req = 3'b010; #1;
        check("ooo rsp 001", DW'(re_valid), DW'(3'b001));
        check("simul r_rdy", DW'(r_rdy), DW'(3'b010));
        cyc(); r_req = '0; #1;
        check("simul rd_cnt=2", DW'(rd_cnt), DW'(2));
        check("ooo rsp 100b", DW'(re_valid), DW'(3'b100));
        cyc();
        check("simul owner 1", DW'(re_valid), DW'(3'b010));
        cyc(); m_re_valid = 1'b0; #1;
        check("simul drained", DW'(rd_cnt), '0);

        // spurious response with nothing outstanding
        m_re_valid = 1'b1; #1;
        check("spurious re_valid", DW'(re_valid), '0);
        cyc(); m_re_valid = 1'b0; #1;
        check("spurious rsp_err", DW'(rsp_err), DW'(1'b1));
        check("spurious rd_cnt", DW'(rd_cnt), '0);
        cyc();
        check("rsp_err sticky", DW'(rsp_err), DW'(1'b1));

        // writes from masters 0 and 2, concurrent reads from 0 then 1
        w_req = 3'b101; m_w_rdy = 1'b1;
        w_addr = {32'h0000_2222, 32'h0000_1111, 32'h0000_0000};
        w_strb = {16'hF000, 16'h0FF0, 16'h000F};
        w_data = {DATA_D, DATA_B, DATA_C};
        r_req = 3'b001; #1;
        check("wr grant 0", DW'(w_rdy), DW'(3'b001));
        check("wr m_w_req", DW'(m_w_req), DW'(1'b1));
        check("wr strb 0", DW'(m_w_strb), DW'(16'h000F));
        check("wr data 0", m_w_data, DATA_C);
        check("wr+rd same master", DW'(r_rdy), DW'(3'b001));
        cyc(); w_req = 3'b100; r_req = 3'b010; #1;
        check("wr grant 2", DW'(w_rdy), DW'(3'b100));
        check("wr strb 2", DW'(m_w_strb), DW'(16'hF000));
        check("wr data 2", m_w_data, DATA_D);
        check("wr addr 2", DW'(m_w_addr), DW'(32'h0000_2222));
        check("rd grant 1", DW'(r_rdy), DW'(3'b010));
        cyc(); w_req = '0; r_req = '0; #1;
        check("pre-reset rd_cnt", DW'(rd_cnt), DW'(2));
        check("wr idle", DW'(m_w_req), '0);

        // asynchronous reset with two reads outstanding
        rst_n = 1'b1; #1;
        check("async rst rd_cnt", DW'(rd_cnt), '0);
        check("async rst rsp_err", DW'(rsp_err), '0);
        rst_n = 1'b0; r_req = 3'b111; #1;
        check("async rst rd ptr", DW'(r_rdy), DW'(3'b001));
        r_req = '0; m_re_valid = 1'b1; #1;
        check("post-rst re_valid", DW'(re_valid), '0);
        cyc(); m_re_valid = 1'b0; #1;
        check("post-rst rsp_err", DW'(rsp_err), DW'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
